// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the sequential ALU and the CPU controller.
//   - 4-bit opcode map (NOP..HLT, plus SHL/SHR/MUL in the previously unused encodings)
//   - ALU sequencer state encoding (IDLE / MUL_RUN)
package alu_pkg;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] LDO = 4'b0001;
    localparam logic [3:0] LDA = 4'b0010;
    localparam logic [3:0] STO = 4'b0011;
    localparam logic [3:0] PRE = 4'b0100;
    localparam logic [3:0] ADD = 4'b0101;
    localparam logic [3:0] LDM = 4'b0110;
    localparam logic [3:0] ADN = 4'b0111;
    localparam logic [3:0] INC = 4'b1000;
    localparam logic [3:0] DEC = 4'b1001;
    localparam logic [3:0] JMP = 4'b1010;
    localparam logic [3:0] CLR = 4'b1011;
    localparam logic [3:0] SHL = 4'b1100;
    localparam logic [3:0] SHR = 4'b1101;
    localparam logic [3:0] MUL = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial-product bit per clock.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   go             load a/b and start (only issued while busy=0)
//   a, b           multiplicand / multiplier, DATA_W bits
//   busy           iterations still outstanding
//   done           high during the cycle whose clock edge retires the final step
//   product        2*DATA_W-bit result; valid (combinationally) while done=1
// The final-step value is exported combinationally so the parent can register it
// on the same edge the last step is taken, keeping the total latency at DATA_W+1.
module alu_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*DATA_W-1:0] acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        if (go) begin
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            count_d  = CNT_W'(DATA_W);
        end else if (count_q != '0) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    assign busy    = (count_q != '0);
    assign done    = (count_q == CNT_W'(1));
    assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result/flags and a start/busy/done handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, op, alu_in,       operation launch; all sampled together while busy=0
//   accum, pc_in
//   busy                     multiply in progress
//   done                     one-cycle pulse when alu_out/zero_f/carry_f update
//   alu_out, zero_f, carry_f registered result and flags; hold between operations
// Build option: define ALU_MUL_EN to include the sequential multiplier (opcode MUL).
// Without it, MUL completes in one cycle returning accum with carry clear, and busy=0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] accum,
    input  logic              pc_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero_f,
    output logic              carry_f
);
    logic              done_q, done_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              res_c;

    // Single-cycle result from the current operands.
    always_comb begin
        imm_ext              = '0;
        imm_ext[IMM_W-1:0]   = alu_in[IMM_W-1:0];
        sum                  = '0;
        res                  = accum;
        res_c                = 1'b0;
        case (op)
            NOP:                res = pc_in ? alu_in : accum;
            LDO, LDA, PRE, JMP: res = alu_in;
            STO, LDM, HLT:      res = accum;
            ADD: begin
                sum          = {1'b0, accum} + {1'b0, alu_in};
                {res_c, res} = sum;
            end
            ADN: begin
                sum          = {1'b0, accum} + {1'b0, imm_ext};
                {res_c, res} = sum;
            end
            INC: begin
                sum          = {1'b0, accum} + (DATA_W + 1)'(1);
                {res_c, res} = sum;
            end
            DEC: begin
                res   = accum - DATA_W'(1);
                res_c = (accum == '0);
            end
            CLR:     res = '0;
            SHL: begin
                res   = {accum[DATA_W-2:0], 1'b0};
                res_c = accum[DATA_W-1];
            end
            SHR: begin
                res   = {1'b0, accum[DATA_W-1:1]};
                res_c = accum[0];
            end
            // MUL: pass accum through when no multiplier is built; otherwise unused.
            default: res = accum;
        endcase
    end

`ifdef ALU_MUL_EN
    alu_state_e          state_q, state_d;
    logic                mul_go;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .go      (mul_go),
        .a       (accum),
        .b       (alu_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        mul_go    = 1'b0;
        done_d    = 1'b0;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == MUL) begin
                        mul_go  = 1'b1;
                        state_d = MUL_RUN;
                    end else begin
                        done_d    = 1'b1;
                        alu_out_d = res;
                        zero_d    = (res == '0);
                        carry_d   = res_c;
                    end
                end
            end
            MUL_RUN: begin
                // mul_done marks the edge on which the counter reaches zero.
                if (mul_done) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    alu_out_d = mul_product[DATA_W-1:0];
                    zero_d    = (mul_product[DATA_W-1:0] == '0);
                    carry_d   = |mul_product[2*DATA_W-1:DATA_W];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy = mul_busy;
`else
    always_comb begin
        done_d    = 1'b0;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        if (start) begin
            done_d    = 1'b1;
            alu_out_d = res;
            zero_d    = (res == '0);
            carry_d   = res_c;
        end
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            done_q    <= done_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign done    = done_q;
    assign alu_out = alu_out_q;
    assign zero_f  = zero_q;
    assign carry_f = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (DATA_W=8, IMM_W=4).
// Expected results are queued at launch and popped when done is observed.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] alu_in;
    logic [W-1:0] accum;
    logic         pc_in;
    logic         busy;
    logic         done;
    logic [W-1:0] alu_out;
    logic         zero_f;
    logic         carry_f;

    always #5 clk = ~clk;

    alu_seq #(.DATA_W(W), .IMM_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .alu_in  (alu_in),
        .accum   (accum),
        .pc_in   (pc_in),
        .busy    (busy),
        .done    (done),
        .alu_out (alu_out),
        .zero_f  (zero_f),
        .carry_f (carry_f)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic         z;
        logic         c;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse at a falling edge; returns at the next falling edge
    // (cycle 1 after the launching rising edge).
    task automatic launch(input logic [3:0] o, input logic [W-1:0] in, input logic [W-1:0] acc,
                          input logic p, input logic [W-1:0] eo, input logic ez, input logic ec,
                          input int lat, input string tag);
        exp_t e;
        e.tag = tag; e.out = eo; e.z = ez; e.c = ec; e.lat = lat;
        sb.push_back(e);
        start = 1'b1; op = o; alu_in = in; accum = acc; pc_in = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pop_compare(input int cyc, input int busy_cnt);
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_lat"},  cyc,      e.lat);
        check({e.tag, "_busy"}, busy_cnt, e.lat - 1);
        check({e.tag, "_out"},  alu_out,  e.out);
        check({e.tag, "_z"},    zero_f,   e.z);
        check({e.tag, "_c"},    carry_f,  e.c);
        $display("op %s: alu_out=%02h z=%0b c=%0b after %0d cycles", e.tag, alu_out, zero_f, carry_f, cyc);
    endtask

    // Wait (bounded) for done, starting at cycle cyc0 with busy_cnt0 busy cycles seen.
    task automatic collect(input int cyc0, input int busy_cnt0);
        int cyc = cyc0;
        int bc  = busy_cnt0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", done, 1);
            sb.delete();
        end else begin
            check("busy_at_done", busy, 0);
            pop_compare(cyc, bc);
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] in, input logic [W-1:0] acc,
                       input logic p, input logic [W-1:0] eo, input logic ez, input logic ec,
                       input int lat, input string tag);
        launch(o, in, acc, p, eo, ez, ec, lat, tag);
        collect(1, 0);
        @(negedge clk);
        check({tag, "_done_clr"}, done,    0);
        check({tag, "_hold"},     alu_out, eo);
    endtask

    initial begin
        int bc;
        int extra_done;
        rst = 1'b1; start = 1'b0; op = NOP; alu_in = '0; accum = '0; pc_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out",  alu_out, 0);
        check("rst_z",    zero_f, 0);
        check("rst_c",    carry_f, 0);
        rst = 1'b0;
        @(negedge clk);

        run(ADD, 8'h20, 8'hF0, 1'b0, 8'h10, 1'b0, 1'b1, 1, "ADD");
        run(ADN, 8'hAB, 8'h10, 1'b0, 8'h1B, 1'b0, 1'b0, 1, "ADN");
        run(DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1, "DEC");
        run(INC, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1, "INC");
        run(SHL, 8'h00, 8'h81, 1'b0, 8'h02, 1'b0, 1'b1, 1, "SHL");
        run(CLR, 8'h77, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1, "CLR");
        run(LDA, 8'hC3, 8'h11, 1'b0, 8'hC3, 1'b0, 1'b0, 1, "LDA");
        run(STO, 8'hC3, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 1, "STO");
        run(NOP, 8'h5A, 8'h33, 1'b0, 8'h33, 1'b0, 1'b0, 1, "NOP_acc");

`ifdef ALU_MUL_EN
        run(MUL, 8'h0B, 8'h0D, 1'b0, 8'h8F, 1'b0, 1'b0, MUL_LAT, "MUL_8F");
        run(MUL, 8'h10, 8'h20, 1'b0, 8'h00, 1'b1, 1'b1, MUL_LAT, "MUL_200");
`else
        run(MUL, 8'h0B, 8'h0D, 1'b0, 8'h0D, 1'b0, 1'b0, MUL_LAT, "MUL_8F");
        run(MUL, 8'h10, 8'h20, 1'b0, 8'h20, 1'b0, 1'b0, MUL_LAT, "MUL_200");
`endif

`ifdef ALU_MUL_EN
        // INC issued during busy cycle 3 must be ignored.
        launch(MUL, 8'h05, 8'h03, 1'b0, 8'h0F, 1'b0, 1'b0, MUL_LAT, "MUL_rej");
        bc = 0;
        if (busy === 1'b1) bc++;
        @(negedge clk);
        if (busy === 1'b1) bc++;
        @(negedge clk);
        if (busy === 1'b1) bc++;
        start = 1'b1; op = INC; accum = 8'h40; alu_in = 8'h00;
        @(negedge clk);
        start = 1'b0;
        collect(4, bc);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        check("rej_extra_done", extra_done, 0);
        check("rej_hold", alu_out, 8'h0F);
`endif

        // Reset during busy cycle 4 of a MUL: everything clears, no late done.
        launch(MUL, 8'h0B, 8'h0D, 1'b0, 8'h00, 1'b0, 1'b0, MUL_LAT, "MUL_abort");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out",  alu_out, 0);
        check("abort_z",    zero_f, 0);
        check("abort_c",    carry_f, 0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        check("abort_late_done", extra_done, 0);
        $display("op MUL_abort: reset mid-run, late done pulses=%0d", extra_done);

        // NOP(pc_in=1) then SHR issued in the NOP's done cycle.
        launch(NOP, 8'h5A, 8'h33, 1'b1, 8'h5A, 1'b0, 1'b0, 1, "NOP_pc");
        start = 1'b1; op = SHR; accum = 8'h81; alu_in = 8'h00; pc_in = 1'b0;
        begin
            exp_t e;
            e.tag = "SHR_b2b"; e.out = 8'h40; e.z = 1'b0; e.c = 1'b1; e.lat = 1;
            sb.push_back(e);
        end
        check("b2b_nop_done", done, 1);
        pop_compare(1, 0);
        @(negedge clk);
        start = 1'b0;
        collect(1, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
